// File: rtl/skolem_pkg.sv
// Shared types and constants for the XOR-family Skolem stream generator:
// FSM state encoding, LFSR seed/taps and the padded-bit predicate.
package skolem_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // True when bit j of chunk c lies beyond the last real universal bit.
    function automatic logic is_pad_bit(input int n_in, input int w, input int c, input int j);
        return (c * w + j) >= n_in;
    endfunction

endpackage

// File: rtl/skolem_lfsr16.sv
// 16-bit Fibonacci LFSR supplying the free existential bits; advances one
// step per accepted result and never reaches the all-zero lock-up state.
module skolem_lfsr16
    import skolem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_reg;
    logic        feedback;

    assign feedback = ^(state_reg & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LFSR_SEED;
        end else if (step) begin
            state_reg <= {feedback, state_reg[15:1]};
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/skolem_xor_stream.sv
// Streaming Skolem generator for XOR(x)^XOR(y)==TARGET: folds W-bit chunks of x
// into a running parity, then emits y with the last bit fixing up the parity.
module skolem_xor_stream
    import skolem_pkg::*;
#(
    parameter int N_IN   = 6,
    parameter int W      = 2,
    parameter int M      = 2,
    parameter int TARGET = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         cfg_rand,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_y,
    output logic         out_chk
);

    localparam int   CHUNKS = (N_IN + W - 1) / W;
    localparam int   CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic TGT    = 1'((TARGET % 2) != 0);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    logic           acc_reg;
    logic [M-1:0]   y_reg;
    logic           chk_reg;

    logic [15:0]    lfsr_state;
    logic           lfsr_unused;
    logic           in_fire, out_fire, last_chunk;
    logic [W-1:0]   mask_tab [CHUNKS];
    logic [W-1:0]   sel_mask;
    logic           chunk_par, vec_par;
    logic [M-1:0]   y_new;
    logic           chk_new;

    // Padding mask per chunk position; only the final chunk can carry pad bits.
    generate
        for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_mask_chunk
            for (genvar gj = 0; gj < W; gj++) begin : g_mask_bit
                assign mask_tab[gi][gj] = !is_pad_bit(N_IN, W, gi, gj);
            end
        end
    endgenerate

    always_comb begin
        sel_mask = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            if (cnt_reg == CW'(c)) begin
                sel_mask = mask_tab[c];
            end
        end
    end

    assign last_chunk = (cnt_reg == CW'(CHUNKS - 1));
    assign in_fire    = in_valid && (state_reg == ACC) && !flush;
    assign out_fire   = out_ready && (state_reg == HOLD) && !flush;
    assign chunk_par  = ^(in_data & sel_mask);
    assign vec_par    = acc_reg ^ chunk_par;

    // Free bits come from the LFSR (or zero); the top bit absorbs the parity error.
    generate
        if (M > 1) begin : g_multi
            logic [M-2:0] free_bits;
            assign free_bits = cfg_rand ? lfsr_state[M-2:0] : '0;
            assign y_new     = {TGT ^ vec_par ^ (^free_bits), free_bits};
        end else begin : g_single
            assign y_new = TGT ^ vec_par;
        end
    endgenerate

    assign chk_new     = ((vec_par ^ (^y_new)) == TGT);
    assign lfsr_unused = ^lfsr_state;

    skolem_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (out_fire),
        .state (lfsr_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ACC;
        end else begin
            case (state_reg)
                ACC:     if (in_fire && last_chunk) state_next = HOLD;
                HOLD:    if (out_fire)              state_next = ACC;
                default: state_next = ACC;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_reg == ACC);
        out_valid = (state_reg == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            acc_reg <= 1'b0;
            y_reg   <= '0;
            chk_reg <= 1'b0;
        end else if (flush) begin
            cnt_reg <= '0;
            acc_reg <= 1'b0;
        end else if (in_fire) begin
            if (last_chunk) begin
                cnt_reg <= '0;
                acc_reg <= 1'b0;
                y_reg   <= y_new;
                chk_reg <= chk_new;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
                acc_reg <= vec_par;
            end
        end
    end

    assign out_y   = y_reg;
    assign out_chk = chk_reg;

endmodule

// File: doc/skolem_xor_stream.md
# skolem_xor_stream

Sequential, parametrised Skolem-function generator for the XOR (parity) specification family: for a universal vector x of N_IN bits and existential outputs y of M bits, it produces y such that XOR(x) ^ XOR(y) = TARGET. Universal bits arrive serially in W-bit chunks over a valid/ready stream; one y word is returned per completed vector over a second valid/ready stream. It succeeds the fixed 6-in/2-out combinational xor Skolem netlists and sits between the stimulus/streaming front end and the Skolem checker.

## Interface
- N_IN, default 6: universal bits per vector (≥1)
- W, default 2: chunk width (1..N_IN)
- M, default 2: existential outputs (1..17)
- TARGET, default 0: required parity of x ∪ y
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous drop of partial vector / pending result
- cfg_rand  in  1  free-output mode: 0 zeros, 1 LFSR bits
- in_valid  in  1  chunk valid
- in_ready  out  1  chunk accept
- in_data  in  W  chunk; bit j of chunk c is universal bit c*W+j
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_y  out  M  existential vector
- out_chk  out  1  recomputed XOR(x)^XOR(y)==TARGET; always 1 when out_valid

## Operation
- CHUNKS = ceil(N_IN/W); chunk counter 0..CHUNKS-1, wraps to 0 after last chunk.
- Padding: bits with index c*W+j ≥ N_IN are masked out of the parity.
- States: ACC (in_ready=1, out_valid=0), HOLD (in_ready=0, out_valid=1).
- ACC: on in_valid&in_ready, acc ^= XOR(masked in_data), counter++. On the handshake of chunk CHUNKS-1: latch result, clear acc and counter, go HOLD.
- Result: y[M-2:0] = 0 if cfg_rand=0, else LFSR[M-2:0]; y[M-1] = TARGET ^ P ^ XOR(y[M-2:0]), P = full-vector parity including the last chunk. M=1: y[0] = TARGET ^ P.
- cfg_rand sampled on the last-chunk handshake only.
- HOLD: out_y/out_chk stable until out_valid&out_ready, then LFSR advances one step and state returns ACC.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, seed 16'hACE1, never zero.
- flush=1: state→ACC, acc/counter cleared, out_valid dropped, LFSR untouched; a coincident input or output handshake is ignored (flush wins).

## Timing
- Reset values: in_ready=1, out_valid=0, out_y=0, out_chk=0, state ACC, acc=0, counter=0, LFSR=16'hACE1.
- Latency: out_valid rises the cycle after the last-chunk handshake.
- Throughput: CHUNKS+1 cycles per vector minimum (one HOLD cycle, no input/output overlap).
- in_ready and out_valid are registered; no combinational path from out_ready to in_ready.
- Reset asserted mid-vector or in HOLD: immediate return to reset values, partial data discarded.

## Structure
- Package skolem_pkg: state enum (ACC, HOLD), LFSR_SEED, LFSR tap constant, function for padded-bit mask.
- One sub-module: skolem_lfsr16 (clk, rst, step, state[15:0]).
- Parity reduction, mask and y[M-1] fix-up stay in the top level.

## Test plan
- N_IN=6,W=2,M=2,TARGET=0,cfg_rand=0: chunks 01,10,11 → P=0, out_y=2'b00, out_chk=1, out_valid one cycle after third chunk.
- Same config: chunks 01,00,00 → out_y=2'b10; then chunks 11,11,01 → out_y=2'b10.
- N_IN=5,W=2: chunks 00,00,10 → padding bit 5 ignored, out_y=2'b00; chunks 00,00,01 → out_y=2'b10.
- Back-pressure: hold out_ready=0 for 3 cycles → out_y stable, in_ready=0 throughout; counter resumes from 0 after accept.
- flush after chunk 1, and flush coincident with out handshake → next vector 01,00,00 yields 2'b10, LFSR not advanced; rst mid-vector → all outputs at reset values next edge.
- cfg_rand=1, M=5, 1000 random vectors with random stalls → out_chk=1 and parity invariant hold every result; y[3:0] matches reference LFSR sequence from seed 16'hACE1.
